// File: rtl/cla_pkg.sv
// Shared types for the 4-bit carry-lookahead adder slice.
// Result bundle is ordered {cout, sum, grp_g, grp_p} so a cascade parent can slice it directly.
package cla_pkg;

    localparam int CLA_W = 4;

    typedef struct packed {
        logic             cout;
        logic [CLA_W-1:0] sum;
        logic             grp_g;
        logic             grp_p;
    } cla_result_t;

    localparam cla_result_t CLA_RESULT_ZERO = '0;

endpackage

// File: rtl/cla4_core.sv
// Combinational 4-bit carry-lookahead core: sum, carry-out, group generate/propagate.
// Zero latency, no flow control; every carry is a flat sum-of-products of g/p/cin.
module cla4_core
    import cla_pkg::*;
(
    input  logic [CLA_W-1:0] a,
    input  logic [CLA_W-1:0] b,
    input  logic             cin,
    output cla_result_t      res
);

    logic [CLA_W-1:0] g;
    logic [CLA_W-1:0] p;
    logic [CLA_W:0]   c;
    logic             grp_g;
    logic             grp_p;

    assign g = a & b;
    assign p = a ^ b;

    // Each carry is expanded fully so no c[i] waits on c[i-1].
    assign c[0] = cin;
    assign c[1] = g[0]
                | (p[0] & cin);
    assign c[2] = g[1]
                | (p[1] & g[0])
                | (p[1] & p[0] & cin);
    assign c[3] = g[2]
                | (p[2] & g[1])
                | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & cin);
    assign c[4] = g[3]
                | (p[3] & g[2])
                | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & cin);

    assign grp_g = g[3]
                 | (p[3] & g[2])
                 | (p[3] & p[2] & g[1])
                 | (p[3] & p[2] & p[1] & g[0]);
    assign grp_p = &p;

    always_comb begin
        res       = CLA_RESULT_ZERO;
        res.sum   = p ^ c[CLA_W-1:0];
        res.cout  = c[4];
        res.grp_g = grp_g;
        res.grp_p = grp_p;
    end

endmodule

// File: rtl/four_bit_cla_lowprompt.sv
// Registered 4-bit carry-lookahead adder with exported group G/P for cascading.
// One-cycle latency from in_valid to out_valid; no backpressure, result holds while idle.
module four_bit_cla_lowprompt
    import cla_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [CLA_W-1:0] a,
    input  logic [CLA_W-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    output logic [CLA_W-1:0] sum,
    output logic             cout,
    output logic             grp_g,
    output logic             grp_p
);

    cla_result_t res_comb;
    cla_result_t res_q;
    logic        vld_q;

    cla4_core u_core (
        .a   (a),
        .b   (b),
        .cin (cin),
        .res (res_comb)
    );

    // Result only loads on valid input, so X on a/b/cin while idle never reaches the flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_q <= CLA_RESULT_ZERO;
            vld_q <= 1'b0;
        end else begin
            vld_q <= in_valid;
            if (in_valid) begin
                res_q <= res_comb;
            end
        end
    end

    assign out_valid = vld_q;
    assign sum       = res_q.sum;
    assign cout      = res_q.cout;
    assign grp_g     = res_q.grp_g;
    assign grp_p     = res_q.grp_p;

endmodule

// File: tb/tb_four_bit_cla_lowprompt.sv
// Scoreboard bench for four_bit_cla_lowprompt: directed vectors plus exhaustive stream.
module tb_four_bit_cla_lowprompt;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [3:0] a;
    logic [3:0] b;
    logic       cin;
    logic       out_valid;
    logic [3:0] sum;
    logic       cout;
    logic       grp_g;
    logic       grp_p;

    typedef struct packed {
        logic       cin;
        logic       cout;
        logic [3:0] sum;
        logic       g;
        logic       p;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_out = 0;

    always #5 clk = ~clk;

    four_bit_cla_lowprompt dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .sum       (sum),
        .cout      (cout),
        .grp_g     (grp_g),
        .grp_p     (grp_p)
    );

    // Monitor: pops one expectation per presented result.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && out_valid === 1'b1) begin
                n_cmp++;
                if (sb.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_output: got sum=%b cout=%b g=%b p=%b with nothing expected",
                             sum, cout, grp_g, grp_p);
                end else begin
                    e = sb.pop_front();
                    if ({cout, sum, grp_g, grp_p} !== {e.cout, e.sum, e.g, e.p}) begin
                        n_bad++;
                        $display("FAIL result[%0d]: got cout=%b sum=%b g=%b p=%b, expected cout=%b sum=%b g=%b p=%b",
                                 n_out, cout, sum, grp_g, grp_p, e.cout, e.sum, e.g, e.p);
                    end
                    n_cmp++;
                    if (cout !== (grp_g | (grp_p & e.cin))) begin
                        n_bad++;
                        $display("FAIL gp_identity[%0d]: cout=%b, expected g|(p&cin)=%b",
                                 n_out, cout, grp_g | (grp_p & e.cin));
                    end
                    n_out++;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got {vld,cout,sum,g,p}=%b, expected %b", name, act, exp);
        end
    endtask

    task automatic issue(input logic [3:0] ta, input logic [3:0] tb_v, input logic tc,
                         input logic [3:0] es, input logic ec, input logic eg, input logic ep);
        @(posedge clk);
        #2;
        in_valid = 1'b1;
        a        = ta;
        b        = tb_v;
        cin      = tc;
        sb.push_back(exp_t'{cin: tc, cout: ec, sum: es, g: eg, p: ep});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [8:0] v;
        logic [4:0] full;
        rst_n    = 1'b0;
        in_valid = 1'b1;
        a        = 4'hF;
        b        = 4'hF;
        cin      = 1'b1;

        // Reset held with valid input present: outputs stay cleared.
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("reset_hold", {out_valid, cout, sum, grp_g, grp_p}, 8'h00);
        end

        @(posedge clk);
        #2;
        rst_n = 1'b1;
        sb.push_back(exp_t'{cin: 1'b1, cout: 1'b1, sum: 4'b1111, g: 1'b1, p: 1'b0});

        // Basic adds
        issue(4'b0001, 4'b0001, 1'b0, 4'b0010, 1'b0, 1'b0, 1'b0);
        issue(4'b0011, 4'b0101, 1'b0, 4'b1000, 1'b0, 1'b0, 1'b0);
        issue(4'b1001, 4'b0110, 1'b0, 4'b1111, 1'b0, 1'b0, 1'b1);
        issue(4'b0111, 4'b0001, 1'b1, 4'b1001, 1'b0, 1'b0, 1'b0);
        // Carry-out and propagate chain
        issue(4'b1111, 4'b0001, 1'b0, 4'b0000, 1'b1, 1'b1, 1'b0);
        issue(4'b1010, 4'b0101, 1'b1, 4'b0000, 1'b1, 1'b0, 1'b1);
        issue(4'b0000, 4'b1111, 1'b1, 4'b0000, 1'b1, 1'b0, 1'b1);
        issue(4'b1101, 4'b0111, 1'b0, 4'b0100, 1'b1, 1'b1, 1'b0);
        issue(4'b1010, 4'b1100, 1'b0, 4'b0110, 1'b1, 1'b1, 1'b0);
        issue(4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0);
        // 11 + 9 + 1 = 21
        issue(4'b1011, 4'b1001, 1'b1, 4'b0101, 1'b1, 1'b1, 1'b0);

        // Stall: result must hold while inputs wander.
        @(posedge clk);
        #2;
        in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            a   = 4'($urandom_range(0, 15));
            b   = 4'($urandom_range(0, 15));
            cin = 1'($urandom_range(0, 1));
            @(posedge clk);
            #3;
            chk("stall_hold", {out_valid, cout, sum, grp_g, grp_p}, 8'b0_1_0101_1_0);
        end

        // Mid-stream reset: loaded result is wiped immediately.
        @(posedge clk);
        #2;
        in_valid = 1'b1;
        a        = 4'd5;
        b        = 4'd3;
        cin      = 1'b0;
        @(posedge clk);
        #1;
        chk("midstream_loaded", {out_valid, cout, sum, grp_g, grp_p}, 8'b1_0_1000_0_0);
        #1;
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        chk("midstream_reset", {out_valid, cout, sum, grp_g, grp_p}, 8'h00);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("post_reset_idle", {out_valid, cout, sum, grp_g, grp_p}, 8'h00);
        end

        // Exhaustive back-to-back stream.
        for (int i = 0; i < 512; i++) begin
            v = i[8:0];
            @(posedge clk);
            #2;
            in_valid = 1'b1;
            cin      = v[8];
            a        = v[7:4];
            b        = v[3:0];
            full     = {1'b0, a} + {1'b0, b} + {4'b0, cin};
            sb.push_back(exp_t'{cin: cin, cout: full[4], sum: full[3:0],
                                g: (({1'b0, a} + {1'b0, b}) > 5'd15), p: &(a ^ b)});
        end
        @(posedge clk);
        #2;
        in_valid = 1'b0;

        for (int k = 0; k < 6 && sb.size() != 0; k++) begin
            @(negedge clk);
        end
        @(negedge clk);
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d results outstanding, expected 0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
